// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_pkg;

  // Which rule chose the next fetch address this cycle.
  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_BR,
    SRC_RET,
    SRC_SEQ,
    SRC_HOLD
  } pc_src_e;

  // Widest address the helper below handles; XLEN must not exceed it.
  localparam int PC_MAX_W       = 64;
  localparam int INST_BYTES_DEF = 4;
  localparam int ALIGN_BITS     = $clog2(INST_BYTES_DEF);

  // Clear the low align_bits bits of an address so every redirect target
  // lands on an instruction boundary.
  function automatic logic [PC_MAX_W-1:0] align_addr(
    input logic [PC_MAX_W-1:0] addr,
    input int unsigned         align_bits
  );
    logic [PC_MAX_W-1:0] mask;
    mask = {PC_MAX_W{1'b1}};
    mask = mask << align_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer whose newest entry sits just below
// the write pointer. When full, a push overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  stack_reg [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;
  logic             pop_ok;

  assign top_idx = ptr_reg - PTR_W'(1);
  assign top     = stack_reg[top_idx];
  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(RAS_DEPTH));
  assign pop_ok  = pop && !empty;

  // Decide the pointer/count update and which slot (if any) gets written.
  always_comb begin
    ptr_next   = ptr_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
    wr_idx     = ptr_reg;
    if (clear) begin
      ptr_next   = '0;
      count_next = '0;
    end else if (push && pop_ok) begin
      // Call and return together: swap the top in place.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr_en    = 1'b1;
      ptr_next = ptr_reg + PTR_W'(1);
      if (!full) begin
        count_next = count_reg + CNT_W'(1);
      end
    end else if (pop_ok) begin
      ptr_next   = ptr_reg - PTR_W'(1);
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      stack_reg[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch-stage PC generator: prioritised redirect mux, PC register and the
// fetch_valid handshake toward instruction memory.
module pc_fetch_gen
  import pc_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter logic [63:0] RESET_ADDR = 64'h0,
  parameter int          INST_BYTES = 4,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_tar,
  input  logic            call_valid,
  input  logic [XLEN-1:0] call_ret_addr,
  input  logic            ret_valid,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int ALIGN_W = $clog2(INST_BYTES);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic            fetch_valid_reg;
  logic [XLEN-1:0] ras_top;
  logic            ras_push, ras_pop, ras_clear;
  pc_src_e         src;

  function automatic logic [XLEN-1:0] align_x(input logic [XLEN-1:0] a);
    return XLEN'(align_addr(PC_MAX_W'(a), ALIGN_W));
  endfunction

  // A trap flushes the stack and overrides any call/return in the same cycle;
  // a branch leaves the stack alone so a concurrent return still pops.
  assign ras_clear = en && trap_valid;
  assign ras_push  = en && !trap_valid && call_valid;
  assign ras_pop   = en && !trap_valid && ret_valid;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (call_ret_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Pick the highest-priority source for the next fetch address.
  always_comb begin
    src = SRC_HOLD;
    if (trap_valid) begin
      src = SRC_TRAP;
    end else if (br_valid) begin
      src = SRC_BR;
    end else if (ret_valid && !ras_empty) begin
      src = SRC_RET;
    end else if (fetch_ready) begin
      src = SRC_SEQ;
    end
  end

  // Form the next PC from the selected source.
  always_comb begin
    pc_next = pc_reg;
    case (src)
      SRC_TRAP: pc_next = align_x(trap_vec);
      SRC_BR:   pc_next = align_x(br_tar);
      SRC_RET:  pc_next = align_x(ras_top);
      SRC_SEQ:  pc_next = pc_reg + XLEN'(INST_BYTES);
      default:  pc_next = pc_reg;
    endcase
  end

  // PC and request-valid registers; the first enabled cycle out of reset only
  // raises fetch_valid so the reset address is presented before advancing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg          <= XLEN'(RESET_ADDR);
      fetch_valid_reg <= 1'b0;
    end else if (en) begin
      if (!fetch_valid_reg) begin
        fetch_valid_reg <= 1'b1;
      end else begin
        pc_reg <= pc_next;
      end
    end
  end

  assign pc_addr     = pc_reg;
  assign fetch_valid = fetch_valid_reg;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: directed scenarios plus random
// traffic, compared through a scoreboard against a queue-based model.
module tb_pc_fetch_gen;

  localparam int XLEN = 64;
  localparam int DEPTH = 4;

  logic            clk;
  logic            reset;
  logic            en;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] pc_addr;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vec;
  logic            br_valid;
  logic [XLEN-1:0] br_tar;
  logic            call_valid;
  logic [XLEN-1:0] call_ret_addr;
  logic            ret_valid;
  logic            ras_empty;
  logic            ras_full;

  pc_fetch_gen #(
    .XLEN       (XLEN),
    .RESET_ADDR (64'h0),
    .INST_BYTES (4),
    .RAS_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .pc_addr       (pc_addr),
    .trap_valid    (trap_valid),
    .trap_vec      (trap_vec),
    .br_valid      (br_valid),
    .br_tar        (br_tar),
    .call_valid    (call_valid),
    .call_ret_addr (call_ret_addr),
    .ret_valid     (ret_valid),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        fv;
    logic        emp;
    logic        full;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference state: PC, request flag and the stack as a plain queue
  // (back = newest).
  logic [63:0] m_pc;
  logic        m_fv;
  logic [63:0] m_ras[$];

  // Stimulus staged by the main flow and applied on the next falling edge.
  logic        s_reset, s_en, s_ready, s_trap, s_br, s_call, s_ret;
  logic [63:0] s_tvec, s_btar, s_caddr;

  function automatic logic [63:0] al(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

  task automatic idle();
    s_reset = 1'b1; s_en = 1'b1; s_ready = 1'b0;
    s_trap = 1'b0; s_br = 1'b0; s_call = 1'b0; s_ret = 1'b0;
    s_tvec = '0; s_btar = '0; s_caddr = '0;
  endtask

  // Advance the reference model by one clock edge using the staged inputs.
  task automatic model_step();
    logic [63:0] nxt;
    if (!s_reset) begin
      m_pc = 64'h0;
      m_fv = 1'b0;
      m_ras.delete();
    end else if (s_en) begin
      nxt = m_pc;
      if (s_trap) nxt = al(s_tvec);
      else if (s_br) nxt = al(s_btar);
      else if (s_ret && m_ras.size() > 0) nxt = al(m_ras[m_ras.size()-1]);
      else if (s_ready) nxt = m_pc + 64'd4;
      if (!m_fv) m_fv = 1'b1;
      else m_pc = nxt;
      if (s_trap) begin
        m_ras.delete();
      end else if (s_call && s_ret && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = s_caddr;
      end else if (s_call) begin
        m_ras.push_back(s_caddr);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (s_ret && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    reset = s_reset; en = s_en; fetch_ready = s_ready;
    trap_valid = s_trap; trap_vec = s_tvec;
    br_valid = s_br; br_tar = s_btar;
    call_valid = s_call; call_ret_addr = s_caddr; ret_valid = s_ret;
    model_step();
    e.pc = m_pc; e.fv = m_fv;
    e.emp = (m_ras.size() == 0); e.full = (m_ras.size() == DEPTH);
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("[TB] check %s = %h ok", name, act);
    end
  endtask

  // Scoreboard monitor: after each edge, compare DUT state to the oldest
  // queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (pc_addr !== e.pc || fetch_valid !== e.fv ||
            ras_empty !== e.emp || ras_full !== e.full) begin
          n_fail++;
          $display("[TB] FAIL sb t=%0t: pc=%h fv=%b emp=%b full=%b, expected pc=%h fv=%b emp=%b full=%b",
                   $time, pc_addr, fetch_valid, ras_empty, ras_full, e.pc, e.fv, e.emp, e.full);
        end else begin
          $display("[TB] t=%0t pc=%h fv=%b emp=%b full=%b ok",
                   $time, pc_addr, fetch_valid, ras_empty, ras_full);
        end
      end
    end
  end

  initial begin
    int drain;
    idle();
    s_reset = 1'b0;
    reset = 1'b0; en = 1'b0; fetch_ready = 1'b0;
    trap_valid = 1'b0; trap_vec = '0; br_valid = 1'b0; br_tar = '0;
    call_valid = 1'b0; call_ret_addr = '0; ret_valid = 1'b0;
    m_pc = '0; m_fv = 1'b0;

    // 1: reset, release, sequential stepping and wrap at the top of memory.
    for (int i = 0; i < 3; i++) begin
      idle(); s_reset = 1'b0; s_en = (i != 1); s_ready = 1'b1; tick();
    end
    settle();
    chk("reset_pc", pc_addr, 64'h0);
    chk("reset_fv", {63'b0, fetch_valid}, 64'h0);
    chk("reset_empty", {63'b0, ras_empty}, 64'h1);
    idle(); s_ready = 1'b1; tick();
    settle();
    chk("first_fv", {63'b0, fetch_valid}, 64'h1);
    chk("first_pc", pc_addr, 64'h0);
    for (int i = 0; i < 3; i++) begin
      idle(); s_ready = 1'b1; tick();
    end
    settle();
    chk("step_c", pc_addr, 64'hC);
    idle(); s_br = 1'b1; s_btar = 64'hFFFF_FFFF_FFFF_FFFC; tick();
    idle(); s_ready = 1'b1; tick();
    settle();
    chk("wrap", pc_addr, 64'h0);

    // 2: stall holds the address; a branch redirects despite no ready.
    idle(); s_br = 1'b1; s_btar = 64'h10; tick();
    for (int i = 0; i < 4; i++) begin
      idle(); tick();
    end
    settle();
    chk("stall_hold", pc_addr, 64'h10);
    idle(); s_br = 1'b1; s_btar = 64'h103; tick();
    settle();
    chk("br_align", pc_addr, 64'h100);

    // 3: trap beats branch and empties the stack.
    idle(); s_call = 1'b1; s_caddr = 64'h30; tick();
    idle(); s_trap = 1'b1; s_tvec = 64'h800; s_br = 1'b1; s_btar = 64'h200; tick();
    settle();
    chk("trap_pc", pc_addr, 64'h800);
    chk("trap_empty", {63'b0, ras_empty}, 64'h1);

    // 4: overfill the stack, then unwind it.
    for (int i = 0; i < 5; i++) begin
      idle(); s_call = 1'b1; s_caddr = 64'h40 + 64'(4 * i); tick();
    end
    settle();
    chk("ras_full", {63'b0, ras_full}, 64'h1);
    for (int i = 0; i < 4; i++) begin
      idle(); s_ret = 1'b1; s_ready = 1'b1; tick();
      settle();
      chk("ret_pc", pc_addr, 64'h50 - 64'(4 * i));
    end
    idle(); s_ret = 1'b1; s_ready = 1'b1; tick();
    settle();
    chk("ret_empty_seq", pc_addr, 64'h48);
    chk("ret_empty_flag", {63'b0, ras_empty}, 64'h1);

    // 5: simultaneous call and return swaps the top.
    idle(); s_call = 1'b1; s_caddr = 64'h40; tick();
    idle(); s_call = 1'b1; s_caddr = 64'h60; s_ret = 1'b1; tick();
    settle();
    chk("swap_pc", pc_addr, 64'h40);
    chk("swap_empty", {63'b0, ras_empty}, 64'h0);
    idle(); s_ret = 1'b1; tick();
    settle();
    chk("swap_top", pc_addr, 64'h60);

    // 6: enable low freezes everything; reset mid-stream.
    idle(); s_call = 1'b1; s_caddr = 64'h90; s_br = 1'b1; s_btar = 64'h24; tick();
    idle(); s_en = 1'b0; s_br = 1'b1; s_btar = 64'h300; s_call = 1'b1; s_caddr = 64'h70; s_ready = 1'b1; tick();
    settle();
    chk("en_hold", pc_addr, 64'h24);
    idle(); s_ret = 1'b1; tick();
    settle();
    chk("en_ras_hold", pc_addr, 64'h90);
    idle(); s_br = 1'b1; s_btar = 64'h24; tick();
    idle(); s_reset = 1'b0; s_ready = 1'b1; tick();
    settle();
    chk("mid_reset_pc", pc_addr, 64'h0);
    chk("mid_reset_fv", {63'b0, fetch_valid}, 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      idle();
      s_reset = ($urandom_range(99) != 0);
      s_en    = ($urandom_range(7) != 0);
      s_ready = ($urandom_range(3) != 0);
      s_trap  = ($urandom_range(31) == 0);
      s_br    = ($urandom_range(7) == 0);
      s_call  = ($urandom_range(4) == 0);
      s_ret   = ($urandom_range(4) == 0);
      s_tvec  = {$urandom, $urandom};
      s_btar  = {$urandom, $urandom};
      s_caddr = {$urandom, $urandom};
      tick();
    end

    idle();
    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #3;
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
- Parametrised next-generation program counter for the fetch stage.
- Generates instruction addresses under a valid/ready handshake with instruction memory.
- Accepts prioritised redirects (trap, resolved branch, predicted return) and holds a small return-address stack (RAS) for call/return prediction.
- Sits between the execute/trap logic and the I-side memory port.

Parameters:
- XLEN, 64, address width in bits.
- RESET_ADDR, 64'h0, PC value loaded on reset (truncated to XLEN).
- INST_BYTES, 4, sequential increment; power of two; target low log2(INST_BYTES) bits forced to 0.
- RAS_DEPTH, 4, RAS entries; power of two, 2..16.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  global enable; when 0 all state holds.
- fetch_ready  in  1  memory accepts pc_addr this cycle.
- fetch_valid  out  1  pc_addr is a valid fetch request.
- pc_addr  out  XLEN  current fetch address.
- trap_valid  in  1  trap redirect request.
- trap_vec  in  XLEN  trap target.
- br_valid  in  1  resolved branch/jump redirect.
- br_tar  in  XLEN  branch target.
- call_valid  in  1  push call_ret_addr onto RAS.
- call_ret_addr  in  XLEN  return address to push.
- ret_valid  in  1  predicted return; pop RAS top as target.
- ras_empty  out  1  RAS count == 0.
- ras_full  out  1  RAS count == RAS_DEPTH.

Behaviour:
- Reset (reset==0 at posedge, regardless of en):
  - pc_addr = RESET_ADDR, fetch_valid = 0.
  - RAS count = 0, pointer = 0, so ras_empty = 1 and ras_full = 0.
- First posedge with reset==1 and en==1 sets fetch_valid = 1. pc_addr does not move on that edge.
- en==0: no register changes, including fetch_valid and the RAS. Inputs are ignored.
- Next-PC selection, evaluated only when en==1 and fetch_valid==1, highest priority first:
  1. trap_valid: pc_addr <= trap_vec.
  2. br_valid: pc_addr <= br_tar.
  3. ret_valid with RAS non-empty: pc_addr <= RAS top.
  4. fetch_ready: pc_addr <= pc_addr + INST_BYTES, wrapping mod 2^XLEN.
  5. Otherwise: hold.
- Redirects (rules 1–3) take effect in 1 cycle and ignore fetch_ready. An un-accepted request is dropped (flush semantics).
- Handshake: while fetch_valid && !fetch_ready and no redirect, pc_addr must stay stable.
- All redirect targets have low log2(INST_BYTES) bits cleared before loading.
- RAS updates apply only when en==1:
  - Push (call_valid): write call_ret_addr at pointer, pointer++ (mod RAS_DEPTH), count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten.
  - Pop (ret_valid, count>0): pointer--, count--.
  - Pop when empty: no pop, no redirect; falls to rule 4/5.
  - Push and pop in the same cycle: target = old top; old top is replaced by call_ret_addr; count and pointer are unchanged. When empty, this is a push only.
  - trap_valid: clears RAS (count = 0) on the same edge. Any simultaneous call/ret is ignored.
  - br_valid does not modify the RAS. A simultaneous ret still pops but is not the target, because the branch wins.
- ras_empty and ras_full are combinational from count.

Decomposition:
- Package pc_pkg holds:
  - redirect-source enum {SRC_TRAP, SRC_BR, SRC_RET, SRC_SEQ, SRC_HOLD};
  - localparam ALIGN_BITS = $clog2(INST_BYTES);
  - function align_addr().
- Sub-module pc_ras (XLEN, RAS_DEPTH) contains the circular buffer, pointer, count, push/pop/clear logic and top output.
- pc_fetch_gen contains the priority mux, the PC register and fetch_valid.

Test Plan:
1. Hold reset=0 three cycles, then release with en=1 and fetch_ready=1. Required: pc_addr = 0 and fetch_valid = 0 during reset; fetch_valid = 1 the next cycle; pc_addr then steps 0, 4, 8, C; with XLEN=64, pc = 64'hFFFF_FFFF_FFFF_FFFC steps to 0.
2. fetch_valid=1, fetch_ready=0 for 4 cycles at pc=0x10. Required: pc holds 0x10. Then drive br_valid with br_tar=0x103 while fetch_ready is still 0. Required: pc = 0x100 the next cycle.
3. Assert trap_valid (trap_vec=0x800) and br_valid (br_tar=0x200) in the same cycle. Required: pc = 0x800 and ras_empty = 1.
4. Push 0x40, 0x44, 0x48, 0x4C, 0x50 with RAS_DEPTH=4. Required: ras_full = 1. Then 4 returns. Required: pc = 0x50, 0x4C, 0x48, 0x44. A 5th return gives a sequential increment and ras_empty = 1.
5. RAS top=0x40; assert call_valid (0x60) and ret_valid together. Required: pc = 0x40, count unchanged, top = 0x60.
6. en=0 while br_valid and call_valid are asserted. Required: no pc change and no RAS change. Also pull reset low mid-stream at pc=0x24. Required: pc = 0 and fetch_valid = 0 on that edge.
